fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
Packet-granular round-robin scheduler that drains NUM_QUEUES upstream small FIFOs into one output stream. The upstream FIFOs have no fallthrough: data is valid the cycle after rd_en. The block owns each FIFO's rd_en. It keeps a whole packet, delimited by an EOP bit in the data word, contiguous on the output and presents it through a 2-entry valid/ready output buffer. It sits between the per-port input FIFOs and the shared downstream datapath.

Parameters:
NUM_QUEUES, 4, number of upstream FIFOs (2..16).
DATA_WIDTH, 72, word width including the EOP flag.
EOP_BIT, 71, bit index of the end-of-packet flag within a word.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_empty  in  NUM_QUEUES  per-FIFO empty flag
in_rd_en  out  NUM_QUEUES  per-FIFO read strobe; at most one bit high per cycle
in_data  in  NUM_QUEUES*DATA_WIDTH  FIFO douts; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
out_data  out  DATA_WIDTH  output word (head of buffer)
out_vld  out  1  out_data valid
out_rdy  in  1  downstream accept; a word transfers when out_vld & out_rdy
grant  out  clog2(NUM_QUEUES)  queue currently granted
busy  out  1  high in XFER state

Behaviour:
- Reset values: in_rd_en=0, out_vld=0, out_data=0, grant=0, busy=0, rr pointer=0, buffer count=0, in-flight flag=0, state IDLE. Reset mid-packet drops the in-flight word and the buffered words; no partial packet is emitted after reset.
- State IDLE:
  - If any in_empty bit is low, pick the first non-empty queue at or after the rr pointer (wrapping modulo NUM_QUEUES).
  - Set grant to that queue and go to XFER. No read is issued in the IDLE cycle.
- State XFER, read issue:
  - in_rd_en[grant] = !in_empty[grant] & space & !eop_seen.
  - rd_vld is a registered copy of the previous cycle's read issue.
  - eop_seen = rd_vld & in_data[grant][EOP_BIT]. This is a combinational look at the returning word, so a read is never issued past an EOP.
  - Throughput is 1 word/cycle.
- Space rule: cnt + rd_vld - pop < 2, where pop = out_vld & out_rdy and cnt is the buffer occupancy (0..2). The buffer never overflows.
- Capture: when rd_vld, in_data[grant] is written into the buffer at the end of that cycle. Read-to-output latency is 2 cycles (rd_en at t, word visible on out_data at t+2 if the buffer is empty).
- Packet end: on the cycle eop_seen is high:
  - rr pointer <= grant+1, wrapping;
  - state <= IDLE.
  The next grant can issue its first read 2 cycles after the EOP word returns.
- Empty mid-packet: stay granted and stall with no reads until the FIFO refills. There is no timeout.
- out_vld = (cnt != 0). Order within the buffer is FIFO. Simultaneous capture and pop in the same cycle is legal and leaves cnt unchanged.
- grant is stable for the whole of XFER.

Optional Feature:
- Macro: FIFO_RR_SCHEDULER_STATS_EN.
- When defined:
  - Extra output pkt_count, NUM_QUEUES*32 bits.
  - Each 32-bit per-queue counter increments when eop_seen occurs for that queue and wraps at 2^32.
  - Counters are cleared by reset.
- When undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_rr_scheduler_pkg holds:
  - state enum {IDLE, XFER};
  - GRANT_W = clog2(NUM_QUEUES) helper;
  - BUF_DEPTH = 2.
- One sub-module, rr_pick, is combinational: it takes (req vector, pointer) and returns (found, index). It is reused by other arbiters.

Test Plan:
1. Queue 0 holds a 3-word packet, others empty, out_rdy=1 -> in_rd_en[0] high for 3 consecutive cycles; 3 words out in order; EOP on the 3rd; afterwards rr pointer=1 and state IDLE.
2. Queues 0, 1 and 3 each hold a 2-word packet -> grant sequence 0,1,3; each packet contiguous on the output; no read of queue 2.
3. Queue 2 packet of 4 words, with in_empty[2] forced high for 5 cycles after word 2 -> scheduler stays on grant 2 with no reads, resumes, and emits all 4 words contiguously with no other queue interleaved.
4. 8-word packet with out_rdy low for 6 cycles from word 1 -> cnt never exceeds 2, no word lost or duplicated, all 8 words delivered once out_rdy returns.
5. Queue 1 holds two back-to-back packets (2 words + 2 words), queue 2 holds one packet -> order: queue 1 packet A, then queue 2, then queue 1 packet B; no read issued after A's EOP word.
6. Reset asserted mid-packet (word 2 of 5) -> the next cycle shows out_vld=0 and in_rd_en=0; after release, grant=0 and the pointer restarts at queue 0. With STATS_EN defined, pkt_count is all zeros after reset.

Source files
------------

// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and sizing helpers for the packet round-robin FIFO scheduler.
// Holds the FSM state encoding, output buffer depth and grant-width helper.
package fifo_rr_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int BUF_DEPTH = 2;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Shared with other arbiters in the datapath.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr) + i) % N);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Packet-granular round-robin drain of NUM_QUEUES non-fallthrough FIFOs into a
// 2-entry valid/ready buffer. FIFO_RR_SCHEDULER_STATS_EN adds per-queue packet counters.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 72,
    parameter int EOP_BIT    = 71,
    localparam int GRANT_W   = grant_w(NUM_QUEUES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_QUEUES-1:0]           in_empty,
    output logic [NUM_QUEUES-1:0]           in_rd_en,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [GRANT_W-1:0]              grant,
    output logic                            busy
`ifdef FIFO_RR_SCHEDULER_STATS_EN
    ,
    output logic [NUM_QUEUES*32-1:0]        pkt_count
`endif
);

    state_t                state;
    logic [GRANT_W-1:0]    rr_ptr;
    logic [GRANT_W-1:0]    next_ptr;
    logic                  rd_vld;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [DATA_WIDTH-1:0] words [NUM_QUEUES];
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  pick_found;
    logic [GRANT_W-1:0]    pick_idx;
    logic                  eop_seen;
    logic                  pop;
    logic                  space;
    logic                  issue;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_words
        assign words[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(.N(NUM_QUEUES), .W(GRANT_W)) u_pick (
        .req   (~in_empty),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_word = words[grant];
    assign eop_seen = rd_vld & cur_word[EOP_BIT];
    assign pop      = out_vld & out_rdy;
    // Count the word still in flight so the buffer can never overflow.
    assign space    = ({1'b0, cnt} + {2'b0, rd_vld}) < (3'(BUF_DEPTH) + {2'b0, pop});
    assign issue    = (state == XFER) & ~in_empty[grant] & space & ~eop_seen;
    assign next_ptr = (grant == GRANT_W'(NUM_QUEUES - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        in_rd_en        = '0;
        in_rd_en[grant] = issue;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            rd_vld <= 1'b0;
            busy   <= 1'b0;
        end else begin
            rd_vld <= issue;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        state <= XFER;
                        busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (eop_seen) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO: buf0 is always the head presented downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            buf0 <= '0;
        end else begin
            case ({rd_vld, pop})
                2'b10: begin
                    if (cnt == 2'd0) buf0 <= cur_word;
                    else             buf1 <= cur_word;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0 <= cur_word;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= cur_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_vld  = (cnt != 2'd0);
    assign out_data = buf0;

`ifdef FIFO_RR_SCHEDULER_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_QUEUES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) pkt_cnt_q[q] <= '0;
        end else if (eop_seen) begin
            pkt_cnt_q[grant] <= pkt_cnt_q[grant] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_stats
        assign pkt_count[g*32 +: 32] = pkt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: behavioural non-fallthrough FIFOs on
// the input side, an output log, and hand-computed packet orders.
module tb_fifo_rr_scheduler;

    localparam int NQ  = 4;
    localparam int DW  = 72;
    localparam int GW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NQ-1:0]    in_empty;
    logic [NQ-1:0]    in_rd_en;
    logic [NQ*DW-1:0] in_data;
    logic [DW-1:0]    out_data;
    logic             out_vld;
    logic             out_rdy = 1'b1;
    logic [GW-1:0]    grant;
    logic             busy;
`ifdef FIFO_RR_SCHEDULER_STATS_EN
    logic [NQ*32-1:0] pkt_count;
`endif

    fifo_rr_scheduler #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .EOP_BIT(71)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .in_data  (in_data),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .grant    (grant),
        .busy     (busy)
`ifdef FIFO_RR_SCHEDULER_STATS_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO models: data appears the cycle after rd_en.
    logic [DW-1:0] mem [NQ][32];
    int            wp [NQ] = '{default: 0};
    int            rp [NQ] = '{default: 0};
    logic [DW-1:0] dout [NQ] = '{default: '0};
    logic [NQ-1:0] hold = '0;
    logic          flush = 1'b1;

    always @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (flush) rp[q] <= wp[q];
            else if (in_rd_en[q] && rp[q] != wp[q]) begin
                dout[q] <= mem[q][rp[q] % 32];
                rp[q]   <= rp[q] + 1;
            end
        end
    end

    for (genvar g = 0; g < NQ; g++) begin : g_fifo
        assign in_empty[g]          = (rp[g] == wp[g]) || hold[g];
        assign in_data[g*DW +: DW]  = dout[g];
    end

    logic [DW-1:0] out_log [$];
    logic [DW-1:0] exp_q [$];
    int            viol = 0;
    int            errors = 0;
    int            checks = 0;
    int            next_tag = 1;

    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            if (out_vld && out_rdy) out_log.push_back(out_data);
            if ($countones(in_rd_en) > 1) viol++;
            for (int q = 0; q < NQ; q++)
                if (in_rd_en[q] && in_empty[q]) viol++;
        end
    end

    function automatic logic [DW-1:0] mk(input int q, input int tag, input int i, input int len);
        return {(i == len - 1), 39'b0, 8'(q), 8'(tag), 16'(i)};
    endfunction

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_pkt(input int q, input int len, output int tag);
        tag = next_tag;
        next_tag++;
        for (int i = 0; i < len; i++) begin
            mem[q][wp[q] % 32] = mk(q, tag, i, len);
            wp[q] = wp[q] + 1;
        end
    endtask

    task automatic expect_pkt(input int q, input int tag, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mk(q, tag, i, len));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain_check(input string name, input int base, input int budget);
        int n;
        int bad;
        n = 0;
        while ((out_log.size() - base) < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk_int({name, "_timeout"}, int'(n >= budget), 0);
        chk_int({name, "_count"}, out_log.size() - base, exp_q.size());
        bad = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k >= out_log.size() || out_log[base + k] !== exp_q[k]) bad++;
        chk_int({name, "_words_bad"}, bad, 0);
    endtask

    typedef struct {
        bit          do_reset;
        logic [15:0] lens;   // nibble q = packet length loaded into queue q
        logic [15:0] order;  // nibble k = queue expected k-th on the output
        int          norder;
        int          stall;
    } row_t;

    row_t rows [5];
    int   tags [NQ];
    int   base, rbase, stq, n, len, q, bad_g, ta, tb, tc, t0, t2, t3;
    logic rdh [20];
    logic vh [20];
    int   r_first, v_first;

    initial begin
        rows[0] = '{do_reset: 1'b0, lens: 16'h0011, order: 16'h0001, norder: 2, stall: 0};
        rows[1] = '{do_reset: 1'b1, lens: 16'h2022, order: 16'h0310, norder: 3, stall: 0};
        rows[2] = '{do_reset: 1'b0, lens: 16'h0800, order: 16'h0002, norder: 1, stall: 6};
        rows[3] = '{do_reset: 1'b0, lens: 16'h1111, order: 16'h2103, norder: 4, stall: 0};
        rows[4] = '{do_reset: 1'b0, lens: 16'h0302, order: 16'h0020, norder: 2, stall: 0};

        repeat (2) @(negedge clk);
        #1;
        chk_int("rst_out_vld", int'(out_vld), 0);
        chk_word("rst_out_data", out_data, '0);
        chk_int("rst_rd_en", int'(in_rd_en), 0);
        chk_int("rst_grant", int'(grant), 0);
        chk_int("rst_busy", int'(busy), 0);
        reset = 1'b0;
        flush = 1'b0;

        // Single 3-word packet on queue 0: back-to-back reads, 2-cycle latency.
        exp_q.delete();
        base = out_log.size();
        @(negedge clk);
        load_pkt(0, 3, t0);
        expect_pkt(0, t0, 3);
        for (int k = 0; k < 20; k++) begin
            #1;
            rdh[k] = in_rd_en[0];
            vh[k]  = out_vld;
            @(negedge clk);
        end
        r_first = -1;
        v_first = -1;
        for (int k = 19; k >= 0; k--) begin
            if (rdh[k]) r_first = k;
            if (vh[k])  v_first = k;
        end
        chk_int("t1_latency", v_first - r_first, 2);
        chk_int("t1_rd_run", (r_first >= 0 && r_first < 16) ?
                int'({rdh[r_first], rdh[r_first+1], rdh[r_first+2], rdh[r_first+3]}) : -1, 4'b1110);
        drain_check("t1", base, 100);
        chk_int("t1_busy_idle", int'(busy), 0);

        for (int r = 0; r < 5; r++) begin
            if (rows[r].do_reset) apply_reset();
            exp_q.delete();
            base  = out_log.size();
            stq   = int'(rows[r].order[3:0]);
            rbase = rp[stq];
            @(negedge clk);
            for (int qq = 0; qq < NQ; qq++) begin
                len = int'(rows[r].lens[qq*4 +: 4]);
                if (len > 0) load_pkt(qq, len, tags[qq]);
            end
            for (int k = 0; k < rows[r].norder; k++) begin
                q = int'(rows[r].order[k*4 +: 4]);
                expect_pkt(q, tags[q], int'(rows[r].lens[q*4 +: 4]));
            end
            if (rows[r].stall > 0) begin
                n = 0;
                while (!out_vld && n < 20) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk_int($sformatf("row%0d_stall_wait", r), int'(n < 20), 1);
                out_rdy = 1'b0;
                repeat (rows[r].stall) @(negedge clk);
                #1;
                chk_int($sformatf("row%0d_stall_vld", r), int'(out_vld), 1);
                chk_word($sformatf("row%0d_stall_head", r), out_data, exp_q[0]);
                chk_int($sformatf("row%0d_stall_reads", r), rp[stq] - rbase, 2);
                out_rdy = 1'b1;
            end
            drain_check($sformatf("row%0d", r), base, 200);
        end

        // Queue 2 runs dry mid-packet while queue 0 waits; no interleave allowed.
        apply_reset();
        exp_q.delete();
        base  = out_log.size();
        rbase = rp[2];
        @(negedge clk);
        load_pkt(2, 4, t2);
        n = 0;
        while (rp[2] - rbase < 2 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_int("t3_wait", int'(n < 30), 1);
        hold[2] = 1'b1;
        load_pkt(0, 1, t0);
        bad_g = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (grant != 2'd2 || !busy) bad_g++;
        end
        chk_int("t3_grant_held", bad_g, 0);
        chk_int("t3_reads_stalled", rp[2] - rbase, 2);
        hold[2] = 1'b0;
        expect_pkt(2, t2, 4);
        expect_pkt(0, t0, 1);
        drain_check("t3", base, 200);

        // Two packets queued back-to-back on queue 1 must not merge.
        exp_q.delete();
        base  = out_log.size();
        rbase = rp[1];
        @(negedge clk);
        load_pkt(1, 2, ta);
        load_pkt(1, 2, tb);
        load_pkt(2, 2, tc);
        expect_pkt(1, ta, 2);
        expect_pkt(2, tc, 2);
        expect_pkt(1, tb, 2);
        drain_check("t5", base, 200);
        chk_int("t5_q1_reads", rp[1] - rbase, 4);

        // Reset in the middle of a 5-word packet on queue 3 (pointer is at 2).
        rbase = rp[3];
        @(negedge clk);
        load_pkt(3, 5, t3);
        n = 0;
        while (rp[3] - rbase < 2 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_int("t6_wait", int'(n < 30), 1);
        chk_int("t6_grant_pre", int'(grant), 3);
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        #1;
        chk_int("t6_out_vld", int'(out_vld), 0);
        chk_int("t6_rd_en", int'(in_rd_en), 0);
        chk_int("t6_busy", int'(busy), 0);
        chk_int("t6_grant", int'(grant), 0);
`ifdef FIFO_RR_SCHEDULER_STATS_EN
        chk_int("t6_stats_zero", int'(pkt_count != '0), 0);
`endif
        reset = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        base = out_log.size();
        repeat (3) @(negedge clk);
        for (int qq = 0; qq < NQ; qq++) begin
            load_pkt(qq, 1, tags[qq]);
            expect_pkt(qq, tags[qq], 1);
        end
        drain_check("t6", base, 200);
`ifdef FIFO_RR_SCHEDULER_STATS_EN
        for (int qq = 0; qq < NQ; qq++)
            chk_int($sformatf("t6_stats_q%0d", qq), int'(pkt_count[qq*32 +: 32]), 1);
`endif
        chk_int("rd_protocol_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
